// File: rtl/add_result_stage.sv
// Registered status/skid stage behind the ripple-carry adder: captures sum, carry and
// derived N/Z/C/V flags into a 2-entry FIFO and counts signed-overflow results.
module add_result_stage #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             a_msb,
   input  logic             b_msb,
   input  logic [WIDTH-1:0] s,
   input  logic             cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_s,
   output logic             out_n,
   output logic             out_z,
   output logic             out_c,
   output logic             out_v,
   input  logic             ovf_clr,
   output logic [CNT_W-1:0] ovf_count
);

   localparam int EW = WIDTH + 4;

   logic             head_reg;
   logic             tail_reg;
   logic [1:0]       count_reg;
   logic [CNT_W-1:0] ovf_reg;

   logic             flag_n;
   logic             flag_z;
   logic             flag_c;
   logic             flag_v;
   logic [EW-1:0]    entry;
   logic [EW-1:0]    head_entry;
   logic             push;
   logic             pop;

   // Flags are frozen into the entry at accept time; the output side never recomputes them.
   assign flag_n = s[WIDTH-1];
   assign flag_z = (s == '0);
   assign flag_c = cout;
   assign flag_v = (a_msb == b_msb) && (s[WIDTH-1] != a_msb);
   assign entry  = {s, flag_n, flag_z, flag_c, flag_v};

   // Ready depends only on registered occupancy, so out_ready never reaches in_ready.
   assign in_ready  = (count_reg < 2'd2);
   assign out_valid = (count_reg != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_slot
         logic [EW-1:0] slot_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               slot_reg <= '0;
            end else if (push && (tail_reg == 1'(gi))) begin
               slot_reg <= entry;
            end
         end
      end
   endgenerate

   assign head_entry = head_reg ? g_slot[1].slot_reg : g_slot[0].slot_reg;
   assign {out_s, out_n, out_z, out_c, out_v} = head_entry;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_reg  <= 1'b0;
         tail_reg  <= 1'b0;
         count_reg <= 2'd0;
      end else begin
         if (pop) begin
            head_reg <= ~head_reg;
         end
         if (push) begin
            tail_reg <= ~tail_reg;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Clear wins over a same-cycle increment; the count sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_reg <= '0;
      end else if (ovf_clr) begin
         ovf_reg <= '0;
      end else if (push && flag_v && (ovf_reg != '1)) begin
         ovf_reg <= ovf_reg + 1'b1;
      end
   end

   assign ovf_count = ovf_reg;

endmodule

// File: tb/tb_add_result_stage.sv
// Self-checking bench for add_result_stage: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_add_result_stage;

   localparam int W  = 32;
   localparam int CW = 2;
   localparam int OVF_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          a_msb = 1'b0;
   logic          b_msb = 1'b0;
   logic [W-1:0]  s = '0;
   logic          cout = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_s;
   logic          out_n;
   logic          out_z;
   logic          out_c;
   logic          out_v;
   logic          ovf_clr = 1'b0;
   logic [CW-1:0] ovf_count;

   int checks = 0;
   int errors = 0;

   // Reference model: queue of expected {s,n,z,c,v} entries plus overflow count.
   logic [W+3:0] q[$];
   int           ovf_m = 0;

   add_result_stage #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a_msb(a_msb), .b_msb(b_msb), .s(s), .cout(cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_s(out_s), .out_n(out_n), .out_z(out_z), .out_c(out_c), .out_v(out_v),
      .ovf_clr(ovf_clr), .ovf_count(ovf_count)
   );

   always #5 clk = ~clk;

   function automatic logic [W+3:0] mk(input logic [W-1:0] sv, input logic co,
                                       input logic am, input logic bm);
      logic n, z, v;
      n = sv[W-1];
      z = (sv == 0);
      v = (am == bm) && (sv[W-1] != am);
      return {sv, n, z, co, v};
   endfunction

   // Drives one cycle from a negedge and advances the model over the following posedge.
   task automatic step(input logic iv, input logic [W-1:0] sv, input logic co,
                       input logic am, input logic bm, input logic ordy, input logic clr);
      bit           do_push, do_pop;
      logic [W+3:0] e;
      in_valid = iv; s = sv; cout = co; a_msb = am; b_msb = bm;
      out_ready = ordy; ovf_clr = clr;
      do_push = iv && (q.size() < 2);
      do_pop  = (q.size() > 0) && ordy;
      e = mk(sv, co, am, bm);
      @(posedge clk);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
      if (clr) ovf_m = 0;
      else if (do_push && e[0] && ovf_m < OVF_MAX) ovf_m++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      checks++;
      if ({out_valid, in_ready, out_s, out_n, out_z, out_c, out_v, ovf_count} !==
          {1'b0, 1'b1, {W{1'b0}}, 4'b0000, {CW{1'b0}}}) begin
         errors++;
         $display("FAIL reset_state: valid=%b ready=%b s=%h nzcv=%b%b%b%b cnt=%0d, want valid=0 ready=1 all zero",
                  out_valid, in_ready, out_s, out_n, out_z, out_c, out_v, ovf_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_idle: valid=%b ready=%b, want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_flags();
      step(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({out_valid, out_s, out_n, out_z, out_c, out_v, ovf_count} !== {1'b1, 32'h8000_0000, 4'b1001, 2'd1}) begin
         errors++;
         $display("FAIL pos_ovf: valid=%b s=%h nzcv=%b%b%b%b cnt=%0d, want 1 80000000 1001 1",
                  out_valid, out_s, out_n, out_z, out_c, out_v, ovf_count);
      end
      step(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({out_valid, out_s, out_n, out_z, out_c, out_v, ovf_count} !== {1'b1, 32'h7FFF_FFFF, 4'b0011, 2'd2}) begin
         errors++;
         $display("FAIL neg_ovf: valid=%b s=%h nzcv=%b%b%b%b cnt=%0d, want 1 7fffffff 0011 2",
                  out_valid, out_s, out_n, out_z, out_c, out_v, ovf_count);
      end
      step(1'b1, 32'd50, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({out_valid, out_s, out_n, out_z, out_c, out_v, ovf_count} !== {1'b1, 32'd50, 4'b0010, 2'd2}) begin
         errors++;
         $display("FAIL mixed_sign: valid=%b s=%h nzcv=%b%b%b%b cnt=%0d, want 1 00000032 0010 2",
                  out_valid, out_s, out_n, out_z, out_c, out_v, ovf_count);
      end
      step(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({out_valid, out_s, out_n, out_z, out_c, out_v, ovf_count} !== {1'b1, 32'd0, 4'b0100, 2'd2}) begin
         errors++;
         $display("FAIL zero_flag: valid=%b s=%h nzcv=%b%b%b%b cnt=%0d, want 1 00000000 0100 2",
                  out_valid, out_s, out_n, out_z, out_c, out_v, ovf_count);
      end
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flags_drain: valid=%b ready=%b, want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] got[$];
      step(1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_s !== 32'd1) begin
         errors++;
         $display("FAIL bp_full: ready=%b valid=%b s=%0d, want 0 1 1", in_ready, out_valid, out_s);
      end
      step(1'b1, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (in_ready !== 1'b0 || out_s !== 32'd1) begin
         errors++;
         $display("FAIL bp_hold: ready=%b s=%0d, want 0 1", in_ready, out_s);
      end
      for (int i = 0; i < 4; i++) begin
         if (out_valid === 1'b1) got.push_back(out_s);
         step((i < 2) ? 1'b1 : 1'b0, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         if (i == 0) begin
            checks++;
            if (in_ready !== 1'b1 || out_s !== 32'd2) begin
               errors++;
               $display("FAIL bp_no_refill: ready=%b s=%0d, want 1 2", in_ready, out_s);
            end
         end
      end
      checks++;
      if (got.size() != 3 || got[0] !== 32'd1 || got[1] !== 32'd2 || got[2] !== 32'd3) begin
         errors++;
         $display("FAIL bp_order: got %0d entries (%p), want 1 2 3", got.size(), got);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_empty: valid=%b, want 0", out_valid);
      end
   endtask

   task automatic test_streaming();
      logic [W-1:0] sv;
      for (int i = 0; i < 20; i++) begin
         sv = $urandom;
         step(1'b1, sv, 1'(i), 1'b0, 1'b1, 1'b1, 1'b0);
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_s !== sv || out_c !== 1'(i)) begin
            errors++;
            $display("FAIL stream[%0d]: valid=%b ready=%b s=%h c=%b, want 1 1 %h %b",
                     i, out_valid, in_ready, out_s, out_c, sv, 1'(i));
         end
      end
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_saturation();
      int want;
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (ovf_count !== 2'd0) begin
         errors++;
         $display("FAIL sat_clear: cnt=%0d, want 0", ovf_count);
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         want = (i + 1 > 3) ? 3 : i + 1;
         checks++;
         if (ovf_count !== CW'(want)) begin
            errors++;
            $display("FAIL sat[%0d]: cnt=%0d, want %0d", i, ovf_count, want);
         end
      end
      step(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (ovf_count !== 2'd0 || out_v !== 1'b1) begin
         errors++;
         $display("FAIL clr_priority: cnt=%0d v=%b, want 0 1", ovf_count, out_v);
      end
      // Invalid cycles with unknown data must leave everything untouched.
      step(1'b0, 'x, 1'bx, 1'bx, 1'bx, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || ovf_count !== 2'd0) begin
         errors++;
         $display("FAIL idle_x: valid=%b cnt=%0d, want 0 0", out_valid, ovf_count);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] sv;
      logic [W+3:0] want;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: sv = '0;
            1: sv = 32'h8000_0000;
            2: sv = 32'h7FFF_FFFF;
            default: sv = $urandom;
         endcase
         step(1'($urandom_range(0, 3) != 0), sv, 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
         checks++;
         if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) || ovf_count !== CW'(ovf_m)) begin
            errors++;
            $display("FAIL rand_ctrl[%0d]: valid=%b ready=%b cnt=%0d, want %b %b %0d",
                     i, out_valid, in_ready, ovf_count, q.size() > 0, q.size() < 2, ovf_m);
         end
         if (q.size() > 0) begin
            want = q[0];
            checks++;
            if ({out_s, out_n, out_z, out_c, out_v} !== want) begin
               errors++;
               $display("FAIL rand_head[%0d]: got %h_%b%b%b%b, want %h_%b", i,
                        out_s, out_n, out_z, out_c, out_v, want[W+3:4], want[3:0]);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || ovf_count !== 2'd2) begin
         errors++;
         $display("FAIL mid_pre: valid=%b ready=%b cnt=%0d, want 1 0 2", out_valid, in_ready, ovf_count);
      end
      out_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      ovf_m = 0;
      checks++;
      if ({out_valid, in_ready, out_s, out_n, out_z, out_c, out_v, ovf_count} !==
          {1'b0, 1'b1, {W{1'b0}}, 4'b0000, {CW{1'b0}}}) begin
         errors++;
         $display("FAIL mid_reset: valid=%b ready=%b s=%h nzcv=%b%b%b%b cnt=%0d, want 0 1 all zero",
                  out_valid, in_ready, out_s, out_n, out_z, out_c, out_v, ovf_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_s !== 32'd5 || ovf_count !== 2'd0) begin
         errors++;
         $display("FAIL post_reset_push: valid=%b s=%0d cnt=%0d, want 1 5 0", out_valid, out_s, ovf_count);
      end
   endtask

   initial begin
      test_reset();
      test_flags();
      test_backpressure();
      test_streaming();
      test_saturation();
      test_random();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/add_result_stage.md
# add_result_stage

Registered output stage directly downstream of the 32-bit ripple-carry adder. It captures the adder's sum and carry-out, together with the operand sign bits, under a valid/ready handshake. It derives the N/Z/C/V status flags and buffers up to two results in a skid buffer, so the adder's combinational path is cut from downstream consumers. It also keeps a saturating count of signed-overflow events for debug.

## Interface
- WIDTH, 32, operand/sum width in bits (minimum 2)
- CNT_W, 8, width of the overflow event counter

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  adder result presented this cycle
- in_ready  output  1  stage can accept a result this cycle
- a_msb  input  1  bit WIDTH-1 of adder operand a
- b_msb  input  1  bit WIDTH-1 of adder operand b
- s  input  WIDTH  adder sum
- cout  input  1  adder carry-out
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer takes head entry
- out_s  output  WIDTH  buffered sum
- out_n  output  1  negative flag: s[WIDTH-1]
- out_z  output  1  zero flag: s == 0
- out_c  output  1  carry flag: cout
- out_v  output  1  signed overflow: (a_msb == b_msb) && (s[WIDTH-1] != a_msb)
- ovf_clr  input  1  synchronous clear of ovf_count
- ovf_count  output  CNT_W  number of accepted results with V=1, saturating

## Operation
- Storage: 2-entry FIFO (head/tail pointers, 2-bit occupancy). Each entry holds {s, n, z, c, v}, i.e. WIDTH+4 bits.
- Flags are computed combinationally from the inputs and stored with the entry at accept time. They are never recomputed at the output.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (occupancy < 2). It is a registered-state function and never depends on out_ready, so there is no combinational ready path.
- out_valid = (occupancy > 0). out_* are driven from the head entry and are held stable while out_valid && !out_ready.
- Simultaneous push and pop at occupancy 1: occupancy stays 1. The new entry goes to the tail and the head advances.
- Simultaneous push and pop at occupancy 0: impossible, because out_valid is 0.
- At occupancy 2, in_ready = 0. A pop that cycle frees a slot starting next cycle; there is no same-cycle refill.
- Order is strictly FIFO. No entry is dropped or duplicated.
- ovf_count:
  - Increments by 1 on each push whose v = 1.
  - Saturates at 2^CNT_W-1.
  - ovf_clr forces it to 0 and has priority over an increment in the same cycle.
- Inputs with in_valid = 0 are ignored; X on the data inputs is then harmless.

## Timing
- Reset (rst_n low, asynchronous):
  - Occupancy = 0, pointers = 0, ovf_count = 0.
  - out_valid = 0, in_ready = 1.
  - out_s = 0, out_n = out_z = out_c = out_v = 0 (the storage array is cleared).
- Release of rst_n is synchronous to clk. The first push is possible on the first rising edge after release.
- Latency: a result pushed at edge k appears on out_* with out_valid = 1 after edge k, provided it is the head.
- Throughput: one result per cycle sustained when out_ready is held at 1.
- Reset mid-operation: all buffered entries are discarded immediately and no partial pop is visible. ovf_count returns to 0.
- Pointers wrap modulo 2.

## Test plan
- Positive overflow: push s=0x80000000, cout=0, a_msb=0, b_msb=0 (0x7FFFFFFF + 1) -> out_s=0x80000000, n=1, z=0, c=0, v=1; ovf_count=1.
- Negative overflow: push s=0x7FFFFFFF, cout=1, a_msb=1, b_msb=1 (0x80000000 + 0xFFFFFFFF) -> n=0, z=0, c=1, v=1; ovf_count=2.
- Mixed signs and zero:
  - Push 100 + (-50): s=50, cout=1, a_msb=0, b_msb=1 -> v=0, c=1, n=0.
  - Then push s=0, cout=0, both msbs 0 -> z=1.
  - ovf_count is unchanged.
- Backpressure: out_ready=0 with three back-to-back pushes -> in_ready drops to 0 after the second accept and the third is held. Raising out_ready then drains the results in order 1, 2, 3 with no loss.
- Streaming and saturation:
  - out_ready=1 with one push per cycle -> one result per cycle at latency 1.
  - With CNT_W=2 and 5 overflow pushes -> ovf_count=3.
  - ovf_clr asserted together with an overflow push -> ovf_count=0.
- Reset mid-operation: two entries buffered, then rst_n pulsed low between edges -> out_valid=0 and in_ready=1 immediately, all out_*=0, ovf_count=0.
